// File: rtl/condicionador_entradas_if.sv
// Raw board inputs and conditioned levels feeding the access-control block.
// master drives the raw switches/buttons; slave is the conditioner.
interface condicionador_entradas_if;
  logic [3:0] HH0_IN;
  logic [3:0] HH1_IN;
  logic [1:0] B0_IN;
  logic [1:0] B1_IN;
  logic [3:0] HH0;
  logic [3:0] HH1;
  logic [1:0] B0;
  logic [1:0] B1;
  logic       VALID;

  modport master (
    output HH0_IN, HH1_IN, B0_IN, B1_IN,
    input  HH0, HH1, B0, B1, VALID
  );

  modport slave (
    input  HH0_IN, HH1_IN, B0_IN, B1_IN,
    output HH0, HH1, B0, B1, VALID
  );
endinterface

// File: rtl/condicionador_entradas.sv
// Synchronize and debounce board switches/buttons; turn button presses
// into toggled function-select bits, cleared whenever the user ID changes.
module condicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic CLK,
  input logic RST_N,
  condicionador_entradas_if.slave io
);

  // Bit map: [3:0] HH0, [7:4] HH1, [9:8] B0, [11:10] B1 (buttons idle high)
  localparam logic [11:0] RST_VAL = 12'hF00;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_END  = CNT_W'(DEBOUNCE_CYCLES + 2);

  logic [11:0]      raw;
  logic [11:0]      sync1;
  logic [11:0]      sync2;
  logic [11:0]      s;
  logic [11:0]      nxt_s;
  logic [CNT_W-1:0] cnt [12];
  logic [CNT_W-1:0] st;
  logic             valid;
  logic [1:0]       p0;
  logic [1:0]       p1;
  logic             clr0;
  logic             clr1;
  logic [1:0]       b0;
  logic [1:0]       b1;

  assign raw = {io.B1_IN, io.B0_IN, io.HH1_IN, io.HH0_IN};

  always_comb begin
    nxt_s = s;
    for (int i = 0; i < 12; i++) begin
      if (sync2[i] != s[i] && cnt[i] == CNT_MAX)
        nxt_s[i] = sync2[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      s     <= RST_VAL;
      for (int i = 0; i < 12; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      s     <= nxt_s;
      for (int i = 0; i < 12; i++) begin
        if (sync2[i] == s[i] || cnt[i] == CNT_MAX)
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      st <= '0;
    else if (st != ST_END)
      st <= st + CNT_W'(1);
  end

  assign valid = (st == ST_END);

  // Events are captured on the edge the debounced level moves,
  // so press and ID-clear land together one edge later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p0   <= 2'b00;
      p1   <= 2'b00;
      clr0 <= 1'b0;
      clr1 <= 1'b0;
    end else begin
      p0   <= s[9:8] & ~nxt_s[9:8] & {2{valid}};
      p1   <= s[11:10] & ~nxt_s[11:10] & {2{valid}};
      clr0 <= nxt_s[3:1] != s[3:1];
      clr1 <= nxt_s[7:5] != s[7:5];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b0 <= 2'b00;
      b1 <= 2'b00;
    end else begin
      if (!valid || clr0)
        b0 <= 2'b00;
      else
        b0 <= b0 ^ p0;
      if (!valid || clr1)
        b1 <= 2'b00;
      else
        b1 <= b1 ^ p1;
    end
  end

  assign io.HH0   = s[3:0];
  assign io.HH1   = s[7:4];
  assign io.B0    = b0;
  assign io.B1    = b1;
  assign io.VALID = valid;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Bench for condicionador_entradas with a 4-cycle debounce window.
module tb_condicionador_entradas;

  localparam int DC = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  condicionador_entradas_if io ();

  condicionador_entradas #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(20)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .io(io)
  );

  typedef struct {
    logic [3:0] hh0_in;
    logic [3:0] hh1_in;
    logic [3:0] hh0_exp;
    logic [3:0] hh1_exp;
    logic [1:0] b0_exp;
    logic [1:0] b1_exp;
  } vec_t;

  typedef struct {
    logic [3:0] hh0;
    logic [3:0] hh1;
    logic [1:0] b0;
    logic [1:0] b1;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    exp_t e;
    logic [3:0] prev0;
    logic [3:0] prev1;

    vecs[0] = '{4'b1011, 4'b0000, 4'b1011, 4'b0000, 2'b00, 2'b00};
    vecs[1] = '{4'b1011, 4'b0110, 4'b1011, 4'b0110, 2'b00, 2'b00};
    vecs[2] = '{4'b0001, 4'b1111, 4'b0001, 4'b1111, 2'b00, 2'b00};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00};

    io.HH0_IN = 4'h0;
    io.HH1_IN = 4'h0;
    io.B0_IN  = 2'b11;
    io.B1_IN  = 2'b11;

    // Reset held: raw activity must not reach the outputs
    for (int k = 0; k < 8; k++) begin
      io.HH0_IN = 4'($urandom);
      io.HH1_IN = 4'($urandom);
      io.B0_IN  = 2'($urandom);
      io.B1_IN  = 2'($urandom);
      tick(1);
    end
    chk("reset_outs", {3'b0, io.HH0, io.HH1, io.B0, io.B1, io.VALID},
        16'h0);

    io.HH0_IN = 4'h0;
    io.HH1_IN = 4'h0;
    io.B0_IN  = 2'b00;
    io.B1_IN  = 2'b11;
    RST_N = 1'b1;
    tick(DC + 1);
    chk("valid_pre", {15'b0, io.VALID}, 16'h0);
    tick(1);
    chk("valid_edge", {15'b0, io.VALID}, 16'h1);
    tick(3);
    chk("startup_press", {14'b0, io.B0}, 16'h0);
    io.B0_IN = 2'b11;
    tick(8);

    // Switch vectors, scoreboard-checked at the debounce latency
    prev0 = 4'h0;
    prev1 = 4'h0;
    for (int v = 0; v < 4; v++) begin
      io.HH0_IN = vecs[v].hh0_in;
      io.HH1_IN = vecs[v].hh1_in;
      sb.push_back('{vecs[v].hh0_exp, vecs[v].hh1_exp,
                     vecs[v].b0_exp, vecs[v].b1_exp});
      tick(DC + 1);
      chk("sw_hold", {8'b0, io.HH0, io.HH1}, {8'b0, prev0, prev1});
      tick(1);
      e = sb.pop_front();
      chk("sw_vec", {4'b0, io.HH0, io.HH1, io.B0, io.B1},
          {4'b0, e.hh0, e.hh1, e.b0, e.b1});
      prev0 = e.hh0;
      prev1 = e.hh1;
      tick(2);
    end

    // Glitch shorter than the window is rejected
    io.B1_IN = 2'b10;
    tick(3);
    io.B1_IN = 2'b11;
    tick(10);
    chk("glitch", {14'b0, io.B1}, 16'h0);
    io.B1_IN = 2'b10;
    tick(DC + 2);
    chk("b1_pre", {14'b0, io.B1}, 16'h0);
    tick(1);
    chk("b1_toggle", {14'b0, io.B1}, 16'h1);
    tick(3);
    io.B1_IN = 2'b11;
    tick(8);
    chk("b1_release", {14'b0, io.B1}, 16'h1);
    io.B1_IN = 2'b10;
    tick(DC + 3);
    chk("b1_retoggle", {14'b0, io.B1}, 16'h0);
    io.B1_IN = 2'b11;
    tick(8);

    // New-user clear
    io.HH0_IN = 4'b1010;
    tick(8);
    io.B0_IN = 2'b00;
    tick(DC + 3);
    chk("b0_set", {14'b0, io.B0}, 16'h3);
    io.B0_IN = 2'b11;
    tick(8);
    io.HH0_IN = 4'b1100;
    tick(DC + 2);
    chk("clr_pre", {10'b0, io.HH0, io.B0}, {10'b0, 4'b1100, 2'b11});
    tick(1);
    chk("clr", {14'b0, io.B0}, 16'h0);
    io.B0_IN = 2'b00;
    tick(DC + 3);
    io.B0_IN = 2'b11;
    tick(8);
    chk("b0_reset", {14'b0, io.B0}, 16'h3);
    io.HH0_IN = 4'b1010;
    io.B0_IN  = 2'b01;
    tick(DC + 3);
    chk("clr_vs_press", {14'b0, io.B0}, 16'h0);
    io.B0_IN = 2'b11;
    tick(8);
    chk("press_dropped", {14'b0, io.B0}, 16'h0);

    // Both interfaces in the same cycle
    io.B0_IN = 2'b01;
    io.B1_IN = 2'b10;
    tick(DC + 2);
    chk("simul_pre", {12'b0, io.B0, io.B1}, 16'h0);
    tick(1);
    chk("simul", {12'b0, io.B0, io.B1}, {12'b0, 2'b10, 2'b01});
    io.B0_IN = 2'b11;
    io.B1_IN = 2'b11;
    tick(8);

    // Asynchronous reset in the middle of a count
    io.HH1_IN = 4'b1111;
    tick(8);
    chk("hh1_set", {12'b0, io.HH1}, 16'h000F);
    io.HH1_IN = 4'b1001;
    tick(4);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst", {5'b0, io.HH0, io.HH1, io.B0, io.VALID}, 16'h0);
    tick(1);
    RST_N = 1'b1;
    tick(DC + 1);
    chk("count_lost", {12'b0, io.HH1}, 16'h0);
    tick(1);
    chk("hh1_after", {12'b0, io.HH1}, 16'h0009);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/condicionador_entradas.md
# condicionador_entradas

Input conditioning stage placed directly upstream of `pbl`. It takes the raw board switches and push-buttons for both access interfaces and synchronizes them to `CLK`, then debounces every bit. Each momentary button press becomes a persistent toggled function-select bit. Its outputs drive `pbl` inputs `HH0`, `HH1`, `B0`, `B1` directly, so the combinational access-control logic sees only clean, stable levels.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive clocks a synchronized level must hold before it is accepted (10 ms at 50 MHz). Legal range ≥ 2.
- `CNT_W`, default 20: width of the debounce and startup counters. Requires 2^CNT_W > DEBOUNCE_CYCLES+2.

Ports:
- `CLK` input, 1 bit: system clock. One clock domain only.
- `RST_N` input, 1 bit: reset, asynchronous assert, active-low.
- `HH0_IN` input, 4 bits: raw switches, interface 0. Active-high. Bits [3:1] are user ID, bit [0] is function bit.
- `HH1_IN` input, 4 bits: raw switches, interface 1. Same layout as `HH0_IN`.
- `B0_IN` input, 2 bits: raw push-buttons, interface 0. Active-low: 0 means pressed.
- `B1_IN` input, 2 bits: raw push-buttons, interface 1. Active-low.
- `HH0` output, 4 bits: debounced `HH0_IN`, active-high.
- `HH1` output, 4 bits: debounced `HH1_IN`, active-high.
- `B0` output, 2 bits: latched function-select toggles, interface 0.
- `B1` output, 2 bits: latched function-select toggles, interface 1.
- `VALID` output, 1 bit: 1 once the startup settle window has elapsed.

## Operation
- **Synchronizer.** Each of the 12 raw bits passes through a 2-flop synchronizer.
  - Reset value is the inactive level: 0 for switches, 1 for buttons.
- **Debounce.** Each bit has a stable register `S` and a counter `C`.
  - If sync == S: C <= 0.
  - Else if C == DEBOUNCE_CYCLES-1: S <= sync, C <= 0.
  - Else: C <= C+1.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks resets `C` and never reaches `S`.
  - Reset values: S is 0 for switches and 1 for buttons. C is 0.
- **HH0/HH1** are the switch `S` registers, driven directly from flops.
- **Press detect.** A press is a 1→0 transition of a button `S`, registered one cycle as `P`.
- **Toggle latch.** On `P`, the matching `B0`/`B1` bit inverts. Release has no effect.
- **New-user clear.** Any change of an interface's debounced `HH[3:1]` clears that interface's `B` to 2'b00 on the next edge.
  - Clear has priority over a same-cycle press on that interface. That press is discarded, not deferred.
- **Independence.** Interfaces 0 and 1 are independent. Simultaneous events on both are each processed in the same cycle.
- **Startup.** A startup counter runs from reset release. `VALID` rises when it reaches DEBOUNCE_CYCLES+2, then the counter saturates.
  - While VALID=0, presses are ignored and `B` is held at 0.
- **Reset values of outputs.** HH0=HH1=4'h0, B0=B1=2'b00, VALID=0.

## Timing
- Raw switch change held steady: `HH` updates exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
- Button press held steady: the `B` bit toggles at DEBOUNCE_CYCLES+3 edges.
- Switch ID change: `B` clear lands at DEBOUNCE_CYCLES+3 edges, the same cycle a press would.
- `VALID` asserts on edge DEBOUNCE_CYCLES+2 after RST_N deasserts. It stays high until the next reset.
- An RST_N assertion mid-debounce or mid-press immediately forces all registers to reset values, with no clock required. A pending count is lost.
- The counter cannot wrap: it is bounded at DEBOUNCE_CYCLES-1 by the parameter constraint.

## Test plan
Use DEBOUNCE_CYCLES=4 for all scenarios.
1. **Reset and startup.** Hold RST_N=0, toggle raw inputs → all outputs 0. Release → VALID=1 exactly at edge 6. A press during edges 0-5 leaves B0=00.
2. **Clean switch.** HH0_IN 0000→1011 held → HH0=1011 exactly 6 edges later, B0 unchanged.
3. **Glitch.** B1_IN[0]=0 for 3 clocks, then 1 → B1 stays 00. Then hold 0 for 10 clocks → B1=01 at edge 7. Release, press again → B1=00.
4. **New-user clear.** B0=11, HH0_IN[3:1] 101→110 → B0=00 on the edge HH0 updates+1. Repeat with a B0_IN[1] press aligned to the same cycle → B0=00 and the press is dropped.
5. **Simultaneous interfaces.** Press B0_IN[1] and B1_IN[0] on the same edge → B0=10 and B1=01 on the same cycle.
6. **Async reset mid-count.** Assert RST_N=0 at count 2 of a switch change → HH1=0 immediately, before the next clock edge.
